// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit 8-opcode core: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, HALT and timeout detection. Optional retire counter: `define PERF_CNT_EN.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             imm_nz,
    input  logic             EQ,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             WEdmem,
    output logic             WErf,
    output logic             IRwe,
    output logic             PCwe,
    output logic             MUXalu1,
    output logic             MUXalu2,
    output logic             MUXrf,
    output logic [1:0]       MUXtgt,
    output logic [1:0]       FUNCalu,
    output logic [1:0]       MUXpc,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    // Last count value still allowed to wait; an unacked cycle here times out.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            eq_q, eq_d;
    logic            hlt_q, hlt_d;
    logic [TO_W-1:0] to_q, to_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        op_d    = op_q;
        eq_d    = eq_q;
        hlt_d   = hlt_q;
        to_d    = '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)            state_d = S_DECODE;
                else if (to_q == TO_LAST) state_d = S_ERROR;
                else                     to_d    = to_q + TO_W'(1);
            end
            S_DECODE: begin
                op_d    = op;
                hlt_d   = imm_nz;
                state_d = (op == OP_JALR && imm_nz) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                eq_d    = EQ;
                state_d = (op_q == OP_SW || op_q == OP_LW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack)            state_d = S_WB;
                else if (to_q == TO_LAST) state_d = S_ERROR;
                else                     to_d    = to_q + TO_W'(1);
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_ERROR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            eq_q    <= 1'b0;
            hlt_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            hlt_q   <= hlt_d;
            to_q    <= to_d;
        end
    end

    // Moore outputs: decoded from registered state/op_q/eq_q only.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        WEdmem   = 1'b0;
        WErf     = 1'b0;
        IRwe     = 1'b0;
        PCwe     = 1'b0;
        MUXalu1  = 1'b0;
        MUXalu2  = 1'b0;
        MUXrf    = 1'b0;
        MUXtgt   = 2'b00;
        FUNCalu  = 2'b00;
        MUXpc    = 2'b00;
        halted   = 1'b0;
        err      = 1'b0;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (op_q)
                OP_ADD:  begin MUXtgt = 2'b01; end
                OP_ADDI: begin MUXalu2 = 1'b1; MUXrf = 1'b1; MUXtgt = 2'b01; end
                OP_NAND: begin FUNCalu = 2'b01; MUXtgt = 2'b01; end
                OP_LUI:  begin FUNCalu = 2'b10; MUXalu1 = 1'b1; MUXalu2 = 1'b1;
                               MUXrf = 1'b1; MUXtgt = 2'b01; end
                OP_SW:   begin MUXalu2 = 1'b1; MUXrf = 1'b1; end
                OP_LW:   begin MUXalu2 = 1'b1; MUXrf = 1'b1; end
                OP_BEQ:  begin FUNCalu = 2'b11; MUXrf = 1'b1; MUXtgt = 2'b01; end
                default: begin FUNCalu = 2'b10; MUXrf = 1'b1; MUXtgt = 2'b10; end
            endcase
        end
        case (state_q)
            S_FETCH: begin imem_req = 1'b1; IRwe = 1'b1; end
            S_MEM:   begin dmem_req = 1'b1; WEdmem = (op_q == OP_SW); end
            S_WB: begin
                PCwe = 1'b1;
                WErf = !(op_q == OP_SW || op_q == OP_BEQ);
                if (op_q == OP_BEQ && eq_q) MUXpc = 2'b01;
                else if (op_q == OP_JALR)   MUXpc = 2'b10;
            end
            S_HALT:  halted = hlt_q;
            S_ERROR: err    = 1'b1;
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_WB) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-cycle scoreboard of expected
// outputs is built from a small instruction model, then played against the DUT.
module tb_multicycle_control;

    localparam int MEM_TO = 4;

    typedef struct packed {
        logic       imem_req, dmem_req, WEdmem, WErf, IRwe, PCwe, MUXalu1, MUXalu2, MUXrf;
        logic [1:0] MUXtgt, FUNCalu, MUXpc;
        logic       halted, err;
    } out_t;

    typedef struct {
        logic        imem_ack, dmem_ack;
        logic [2:0]  op;
        logic        imm_nz, eq;
        out_t        exp;
        logic [31:0] cnt;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op;
    logic        imm_nz, EQ, imem_ack, dmem_ack;
    logic        imem_req, dmem_req, WEdmem, WErf, IRwe, PCwe, MUXalu1, MUXalu2, MUXrf;
    logic [1:0]  MUXtgt, FUNCalu, MUXpc;
    logic        halted, err;
    logic [31:0] instr_count;
    out_t        outs;

    entry_t      exp_q[$];
    int          cnt_model = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(MEM_TO), .TO_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .imm_nz(imm_nz), .EQ(EQ),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .WEdmem(WEdmem), .WErf(WErf),
        .IRwe(IRwe), .PCwe(PCwe), .MUXalu1(MUXalu1), .MUXalu2(MUXalu2), .MUXrf(MUXrf),
        .MUXtgt(MUXtgt), .FUNCalu(FUNCalu), .MUXpc(MUXpc),
        .halted(halted), .err(err), .instr_count(instr_count)
    );

    assign outs = {imem_req, dmem_req, WEdmem, WErf, IRwe, PCwe, MUXalu1, MUXalu2, MUXrf,
                   MUXtgt, FUNCalu, MUXpc, halted, err};

    function automatic logic [31:0] cexp();
`ifdef PERF_CNT_EN
        return 32'(cnt_model);
`else
        return 32'd0;
`endif
    endfunction

    // Mux/ALU encodings expected in EXEC, MEM and WB for each opcode.
    function automatic out_t mux_of(input logic [2:0] o);
        out_t m = '0;
        case (o)
            3'd0:       begin m.MUXtgt = 2'b01; end
            3'd1:       begin m.MUXalu2 = 1'b1; m.MUXrf = 1'b1; m.MUXtgt = 2'b01; end
            3'd2:       begin m.FUNCalu = 2'b01; m.MUXtgt = 2'b01; end
            3'd3:       begin m.FUNCalu = 2'b10; m.MUXalu1 = 1'b1; m.MUXalu2 = 1'b1;
                              m.MUXrf = 1'b1; m.MUXtgt = 2'b01; end
            3'd4, 3'd5: begin m.MUXalu2 = 1'b1; m.MUXrf = 1'b1; end
            3'd6:       begin m.FUNCalu = 2'b11; m.MUXrf = 1'b1; m.MUXtgt = 2'b01; end
            default:    begin m.FUNCalu = 2'b10; m.MUXrf = 1'b1; m.MUXtgt = 2'b10; end
        endcase
        return m;
    endfunction

    // Entry with random don't-care stimulus; the caller overrides the inputs that matter.
    function automatic entry_t mk(input out_t x);
        entry_t e;
        e.imem_ack = 1'($urandom());
        e.dmem_ack = 1'($urandom());
        e.op       = 3'($urandom());
        e.imm_nz   = 1'($urandom());
        e.eq       = 1'($urandom());
        e.exp      = x;
        e.cnt      = cexp();
        return e;
    endfunction

    task automatic push_err();
        out_t x;
        for (int i = 0; i < 3; i++) begin
            x = '0; x.err = 1'b1;
            exp_q.push_back(mk(x));
        end
    endtask

    // iw/dw: ack wait cycles; a wait >= MEM_TO means the ack never comes.
    task automatic push_instr(input logic [2:0] o, input logic inz, input logic eq_v,
                              input int iw, input int dw);
        entry_t e;
        out_t   x;
        for (int i = 0; i < MEM_TO && i <= iw; i++) begin
            x = '0; x.imem_req = 1'b1; x.IRwe = 1'b1;
            e = mk(x); e.imem_ack = (i == iw);
            exp_q.push_back(e);
        end
        if (iw >= MEM_TO) begin push_err(); return; end
        x = '0; e = mk(x); e.op = o; e.imm_nz = inz;
        exp_q.push_back(e);
        if (o == 3'd7 && inz) begin
            for (int i = 0; i < 3; i++) begin
                x = '0; x.halted = 1'b1;
                exp_q.push_back(mk(x));
            end
            return;
        end
        e = mk(mux_of(o)); e.eq = eq_v;
        exp_q.push_back(e);
        if (o == 3'd4 || o == 3'd5) begin
            for (int i = 0; i < MEM_TO && i <= dw; i++) begin
                x = mux_of(o); x.dmem_req = 1'b1; x.WEdmem = (o == 3'd4);
                e = mk(x); e.dmem_ack = (i == dw);
                exp_q.push_back(e);
            end
            if (dw >= MEM_TO) begin push_err(); return; end
        end
        x = mux_of(o); x.PCwe = 1'b1; x.WErf = !(o == 3'd4 || o == 3'd6);
        x.MUXpc = (o == 3'd6 && eq_v) ? 2'b01 : (o == 3'd7) ? 2'b10 : 2'b00;
        e = mk(x); e.eq = !eq_v;
        exp_q.push_back(e);
        cnt_model++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outs got=%h expected=%h", outs, out_t'('0)); end
        checks++;
        if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d expected=0", instr_count); end
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_outs got=%h expected=%h", outs, out_t'('0)); end
        checks++;
        if (instr_count !== 32'd0) begin errors++; $display("FAIL idle_count got=%0d expected=0", instr_count); end
    endtask

    task automatic test_alu();
        entry_t e;
        push_instr(3'd0, 1'b0, 1'b0, 0, 0);
        push_instr(3'd1, 1'b0, 1'b1, 1, 0);
        push_instr(3'd2, 1'b1, 1'b0, 0, 0);
        push_instr(3'd3, 1'b0, 1'b1, 2, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL alu_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL alu_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
    endtask

    task automatic test_mem();
        entry_t e;
        push_instr(3'd5, 1'b0, 1'b0, 0, 2);
        push_instr(3'd4, 1'b1, 1'b1, 0, 0);
        push_instr(3'd5, 1'b0, 1'b1, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL mem_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL mem_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
    endtask

    task automatic test_branch();
        entry_t e;
        push_instr(3'd6, 1'b0, 1'b1, 0, 0);
        push_instr(3'd6, 1'b1, 1'b0, 1, 0);
        push_instr(3'd7, 1'b0, 1'b1, 0, 0);
        push_instr(3'd7, 1'b0, 1'b0, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL branch_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL branch_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
    endtask

    task automatic test_back_to_back();
        entry_t     e;
        logic [2:0] o;
        for (int n = 0; n < 12; n++) begin
            o = 3'($urandom());
            push_instr(o, (o == 3'd7) ? 1'b0 : 1'($urandom()), 1'($urandom()),
                       int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL b2b_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL b2b_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
    endtask

    task automatic test_halt();
        entry_t e;
        push_instr(3'd0, 1'b0, 1'b0, 0, 0);
        push_instr(3'd7, 1'b1, 1'b0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL halt_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL halt_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
        test_reset();
    endtask

    task automatic test_fetch_timeout();
        entry_t e;
        push_instr(3'd2, 1'b0, 1'b0, MEM_TO - 1, 0);
        push_instr(3'd0, 1'b0, 1'b0, MEM_TO, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL fetch_to_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL fetch_to_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
        test_reset();
    endtask

    task automatic test_mem_timeout();
        entry_t e;
        push_instr(3'd5, 1'b0, 1'b0, 0, MEM_TO - 1);
        push_instr(3'd4, 1'b0, 1'b0, 0, MEM_TO);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL mem_to_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL mem_to_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
        test_reset();
    endtask

    // Stops inside the first MEM cycle of a store and resets there.
    task automatic test_reset_mid();
        entry_t e;
        push_instr(3'd4, 1'b0, 1'b0, 0, 3);
        while (exp_q.size() > 4) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            imem_ack = e.imem_ack; dmem_ack = e.dmem_ack; op = e.op; imm_nz = e.imm_nz; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (outs !== e.exp) begin errors++; $display("FAIL mid_outs got=%h expected=%h", outs, e.exp); end
            checks++;
            if (instr_count !== e.cnt) begin errors++; $display("FAIL mid_count got=%0d expected=%0d", instr_count, e.cnt); end
        end
        test_reset();
    endtask

    initial begin
        rst_n    = 1'b0;
        op       = 3'd0;
        imm_nz   = 1'b0;
        EQ       = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_back_to_back();
        test_halt();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_mid();
        test_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
